// File: rtl/bldc_duty_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bldc_duty_sequencer_pkg
// Shared BLDC types for the command sequencer and its timing helpers.
//   rotation_direction_t : direction code shared with the commutation driver
//   sequencer_state_t    : 3-bit state code, also exported on seq_state
//   us_to_cycles()       : converts a period in microseconds to sys_clk cycles
// -----------------------------------------------------------------------------
package bldc_duty_sequencer_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } rotation_direction_t;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_RUN       = 3'd1,
    SEQ_RAMP_DOWN = 3'd2,
    SEQ_WAIT_STOP = 3'd3,
    SEQ_FAULT     = 3'd4
  } sequencer_state_t;

  // Whole cycles per microsecond, then scaled; clock rates are integer MHz.
  function automatic int unsigned us_to_cycles(input int unsigned clk_freq_hz,
                                               input int unsigned period_us);
    return (clk_freq_hz / 1_000_000) * period_us;
  endfunction

endpackage

// File: rtl/bldc_duty_sequencer_tick.sv
// -----------------------------------------------------------------------------
// tick_generator
// Free-running prescaler producing a single-cycle pulse every period_us.
//   sys_clk : clock
//   reset_n : asynchronous active-low reset (prescaler restarts at 0)
//   tick    : registered 1-cycle pulse, once per period
// -----------------------------------------------------------------------------
module tick_generator
  import bldc_duty_sequencer_pkg::*;
#(
  parameter int unsigned clk_freq_hz = 54_000_000,
  parameter int unsigned period_us   = 100
) (
  input  logic sys_clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned period_cycles = us_to_cycles(clk_freq_hz, period_us);
  localparam int unsigned cnt_width     = (period_cycles > 1) ? $clog2(period_cycles) : 1;
  localparam logic [cnt_width-1:0] last_count = cnt_width'(period_cycles - 1);

  logic [cnt_width-1:0] count;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == last_count) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + cnt_width'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/bldc_duty_sequencer.sv
// -----------------------------------------------------------------------------
// bldc_duty_sequencer
// Command sequencer feeding the table-commutated BLDC driver. Slews the duty
// toward its target at a fixed rate, sequences direction reversals through a
// confirmed standstill, and forces a coast on Hall errors.
//   sys_clk, reset_n  : clock, asynchronous active-low reset
//   cmd_enable        : run request
//   cmd_direction     : requested direction
//   cmd_duty          : target duty (clamped to pwm_cycle_ticks)
//   pwm_cycle_ticks   : PWM period from the driver, used as duty ceiling
//   rpm               : measured speed from the driver
//   hall_error        : invalid Hall code from the driver
//   drv_enable        : driver enable (registered)
//   drv_direction     : driver direction (registered)
//   drv_duty          : driver duty (registered)
//   seq_state         : current state code (registered)
//   fault             : high while in FAULT (registered)
// -----------------------------------------------------------------------------
module bldc_duty_sequencer
  import bldc_duty_sequencer_pkg::*;
#(
  parameter int unsigned clk_freq_hz        = 54_000_000,
  parameter int unsigned pwm_counter_width  = 11,
  parameter int unsigned counter_width      = 32,
  parameter int unsigned ramp_tick_us       = 100,
  parameter int unsigned duty_step          = 4,
  parameter int unsigned stop_confirm_ticks = 2000,
  parameter int unsigned stop_timeout_ticks = 50000
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         cmd_enable,
  input  rotation_direction_t          cmd_direction,
  input  logic [pwm_counter_width-1:0] cmd_duty,
  input  logic [pwm_counter_width-1:0] pwm_cycle_ticks,
  input  logic [counter_width-1:0]     rpm,
  input  logic                         hall_error,
  output logic                         drv_enable,
  output rotation_direction_t          drv_direction,
  output logic [pwm_counter_width-1:0] drv_duty,
  output logic [2:0]                   seq_state,
  output logic                         fault
);

  localparam int unsigned dw  = pwm_counter_width;
  localparam int unsigned scw = $clog2(stop_confirm_ticks + 1);
  localparam int unsigned tcw = $clog2(stop_timeout_ticks + 1);

  localparam logic [dw-1:0]  step          = dw'(duty_step);
  localparam logic [scw-1:0] stop_confirm  = scw'(stop_confirm_ticks);
  localparam logic [tcw-1:0] timeout_limit = tcw'(stop_timeout_ticks);

  sequencer_state_t    state, next_state;
  rotation_direction_t dir_next;
  logic [dw-1:0]       duty_next, target, duty_to_target, duty_to_zero;
  logic [scw-1:0]      stop_cnt, stop_next;
  logic [tcw-1:0]      timeout_cnt, timeout_next;
  logic                tick;

  tick_generator #(
    .clk_freq_hz (clk_freq_hz),
    .period_us   (ramp_tick_us)
  ) u_tick (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Candidate duties for this tick; the FSM picks which one is applied.
  // Each step is limited to the remaining distance so it lands exactly on
  // the goal and can never wrap past 0 or overshoot the target.
  always_comb begin
    target         = (cmd_duty > pwm_cycle_ticks) ? pwm_cycle_ticks : cmd_duty;
    duty_to_target = drv_duty;
    if (drv_duty < target) begin
      duty_to_target = ((target - drv_duty) > step) ? drv_duty + step : target;
    end else if (drv_duty > target) begin
      duty_to_target = ((drv_duty - target) > step) ? drv_duty - step : target;
    end
    duty_to_zero = (drv_duty > step) ? drv_duty - step : '0;
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    duty_next    = drv_duty;
    dir_next     = drv_direction;
    stop_next    = stop_cnt;
    timeout_next = timeout_cnt;

    unique case (state)
      SEQ_IDLE: begin
        duty_next = '0;
        dir_next  = DIR_NONE;
        if (cmd_enable && (cmd_direction != DIR_NONE) && !hall_error) begin
          next_state = SEQ_RUN;
          dir_next   = cmd_direction;
        end
      end

      SEQ_RUN: begin
        if (hall_error) begin
          next_state = SEQ_FAULT;
          duty_next  = '0;
        end else if (!cmd_enable || (cmd_direction != drv_direction)) begin
          next_state = SEQ_RAMP_DOWN;
          if (tick) duty_next = duty_to_zero;
        end else if (tick) begin
          duty_next = duty_to_target;
        end
      end

      SEQ_RAMP_DOWN: begin
        if (hall_error) begin
          next_state = SEQ_FAULT;
          duty_next  = '0;
        end else begin
          if (tick) duty_next = duty_to_zero;
          // Leave as soon as the registered duty will be 0, so enable drops
          // in the same cycle the zero duty appears.
          if (duty_next == '0) begin
            next_state   = SEQ_WAIT_STOP;
            stop_next    = '0;
            timeout_next = '0;
          end
        end
      end

      SEQ_WAIT_STOP: begin
        duty_next = '0;
        if (hall_error) begin
          next_state = SEQ_FAULT;
        end else if (tick) begin
          // A single nonzero rpm sample restarts the standstill confirmation.
          stop_next    = (rpm == '0) ? stop_cnt + scw'(1) : '0;
          timeout_next = timeout_cnt + tcw'(1);
          if (stop_next == stop_confirm) begin
            if (cmd_enable && (cmd_direction != DIR_NONE)) begin
              next_state = SEQ_RUN;
              dir_next   = cmd_direction;
            end else begin
              next_state = SEQ_IDLE;
              dir_next   = DIR_NONE;
            end
          end else if (timeout_next == timeout_limit) begin
            next_state = SEQ_FAULT;
          end
        end
      end

      SEQ_FAULT: begin
        duty_next = '0;
        if (!cmd_enable && !hall_error) begin
          next_state = SEQ_IDLE;
          dir_next   = DIR_NONE;
        end
      end

      default: begin
        next_state = SEQ_IDLE;
        duty_next  = '0;
        dir_next   = DIR_NONE;
      end
    endcase
  end

  // Outputs are registered from next_state so they change on the same edge
  // as the state itself.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SEQ_IDLE;
      drv_duty      <= '0;
      drv_direction <= DIR_NONE;
      drv_enable    <= 1'b0;
      seq_state     <= 3'd0;
      fault         <= 1'b0;
      stop_cnt      <= '0;
      timeout_cnt   <= '0;
    end else begin
      state         <= next_state;
      drv_duty      <= duty_next;
      drv_direction <= dir_next;
      drv_enable    <= (next_state == SEQ_RUN) || (next_state == SEQ_RAMP_DOWN);
      seq_state     <= next_state;
      fault         <= (next_state == SEQ_FAULT);
      stop_cnt      <= stop_next;
      timeout_cnt   <= timeout_next;
    end
  end

endmodule
